generation_sequencer: RTL and testbench
=======================================

// Module: generation_sequencer
// PURPOSE
//  Top-level controller for the genetic search loop. Drives one family-generation
//  unit (start/done, parent -> 5-member family) per generation.
//  Scores every family member through an external fitness unit, using a req/ack
//  handshake, and promotes the best member to be the next parent.
//  Stops on a generation limit or a fitness target.
//  Sits between the host/test logic and the family generator.
// PARAMETERS
//  GENOME_W   150  bits per genome
//  FAMILY_N   5    members per family; member 0 is the parent
//  FIT_W      16   fitness score width, unsigned
//  GEN_W      16   generation counter width
//  SEED_W     32   PRG seed width
//  TIMEOUT    4096 watchdog limit in cycles (used only with GEN_SEQ_TIMEOUT_EN)
// PORTS
//  clk          in   1                  clock, rising edge
//  rst          in   1                  async reset, active-high
//  start        in   1                  1-cycle pulse; accepted only in IDLE or DONE
//  init_parent  in   GENOME_W           parent loaded on an accepted start
//  seed_init    in   SEED_W             seed loaded on start; 0 is replaced by 1
//  max_gens     in   GEN_W              generation limit; 0 is treated as 1
//  fit_target   in   FIT_W              stop when best_fit >= fit_target
//  iter_start   out  1                  1-cycle pulse to the family generator
//  iter_seed    out  SEED_W             seed to the generator; stable from LAUNCH to UPDATE
//  iter_parent  out  GENOME_W           current parent; stable while busy
//  iter_family  in   GENOME_W*FAMILY_N  family bus, member k at [k*GENOME_W +: GENOME_W]
//  iter_done    in   1                  level from the generator; sampled only in WAIT_IT
//  fit_req      out  1                  fitness request
//  fit_genome   out  GENOME_W           member being scored
//  fit_ack      in   1                  score valid; sampled only while fit_req=1
//  fit_score    in   FIT_W              fitness score
//  busy         out  1                  high in every state except IDLE and DONE
//  done         out  1                  high in DONE; held until the next accepted start
//  best_parent  out  GENOME_W           final parent (equals iter_parent)
//  best_fit     out  FIT_W              best score of the last generation
//  gen_count    out  GEN_W              generations completed
//  err          out  1                  watchdog fired (tied 0 without GEN_SEQ_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (iter_seed, iter_parent, best_* and gen_count cleared).
//   Reset mid-operation aborts immediately; iter_start and fit_req drop at once.
//  FSM IDLE -> LAUNCH -> WAIT_IT -> EVAL -> UPDATE -> (LAUNCH | DONE):
//   IDLE/DONE: start loads parent, seed, limits; clears gen_count, best_fit, err -> LAUNCH.
//   LAUNCH: iter_start=1 for exactly 1 cycle -> WAIT_IT.
//   WAIT_IT: iter_done=1 -> latch iter_family into the family register; k=0 -> EVAL.
//   EVAL: fit_req=1, fit_genome=member k. On fit_ack: compare, fit_req=0 next cycle,
//    k++. After member FAMILY_N-1 is acked -> UPDATE. An ack arriving in the same
//    cycle fit_req rises is legal.
//   Compare: member 0 always seeds best. A later member replaces best only if its
//    score is strictly greater, so ties keep the lower index (parent preferred).
//   UPDATE (1 cycle): iter_parent <= best member; best_fit <= best score; gen_count++;
//    seed advances one Galois LFSR step (poly 0x80200003).
//    Exit to DONE if gen_count(new) == max_gens or best_fit >= fit_target; else LAUNCH.
//  start in any busy state: ignored. gen_count saturates at all-ones.
//  Per-generation latency: 1 + T_iter + sum over members of ack latency + FAMILY_N + 1.
// CONFIGURATION
//  GEN_SEQ_TIMEOUT_EN defined: a watchdog counts cycles in WAIT_IT and in each EVAL request.
//   At TIMEOUT it sets err=1, drops fit_req and goes to DONE. The best_* outputs keep
//   the last completed generation's values.
//  Not defined: no counter; err tied to 0; the controller waits forever.
// STRUCTURE
//  Package gen_pkg: GENOME_W, FAMILY_N, FIT_W, SEED_W, LFSR_POLY, gen_state_t enum.
//  One sub-module: gen_seq_lfsr (load, step, zero-guard), SEED_W wide.
//  FSM, index counter, argmax and watchdog stay in this module.
// TESTING
//  1. max_gens=1, target=FFFF, scores {10,20,5,20,3} -> best index 1, best_fit=20,
//     best_parent=family[299:150], gen_count=1, exactly 1 iter_start, done=1.
//  2. max_gens=10, target=50, gen-1 max score 60 -> DONE after gen 1, gen_count=1.
//  3. max_gens=3, all scores 0, seed_init=1 -> parent unchanged, 3 iter_start pulses,
//     iter_seed equal to 3 LFSR steps from 1.
//  4. seed_init=0, max_gens=0 -> seed loaded as 1, one generation, done.
//  5. rst pulsed mid-EVAL (k=2) -> all outputs 0 immediately, IDLE;
//     start accepted again afterwards; start pulsed in WAIT_IT -> no effect.
//  6. GEN_SEQ_TIMEOUT_EN, TIMEOUT=16, iter_done held 0 -> err=1, done=1 after 16 WAIT_IT cycles.

Source files
------------

// File: rtl/gen_pkg.sv
// Shared constants, FSM state encoding and the seed LFSR step for the
// genetic-search generation sequencer.
package gen_pkg;

  localparam int GENOME_W = 150;
  localparam int FAMILY_N = 5;
  localparam int FIT_W    = 16;
  localparam int GEN_W    = 16;
  localparam int SEED_W   = 32;
  localparam int IDX_W    = 3;

  localparam logic [SEED_W-1:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT_IT = 3'd2,
    S_EVAL    = 3'd3,
    S_UPDATE  = 3'd4,
    S_DONE    = 3'd5
  } gen_state_t;

  // One right-shifting Galois step: shift out bit 0 and fold the taps back in.
  function automatic logic [SEED_W-1:0] lfsr_step(input logic [SEED_W-1:0] s);
    logic [SEED_W-1:0] n;
    n = s >> 1;
    if (s[0]) begin
      n = n ^ LFSR_POLY;
    end else begin
      n = n;
    end
    return n;
  endfunction

endpackage

// File: rtl/gen_seq_lfsr.sv
// Seed register for the family generator: loads a new seed (never zero, since
// an all-zero Galois LFSR would lock up) or advances one LFSR step.
module gen_seq_lfsr
  import gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [SEED_W-1:0] load_val,
  input  logic              step,
  output logic [SEED_W-1:0] seed
);

  logic [SEED_W-1:0] seed_q, seed_d;

  // Next seed: load takes priority over step; a zero load becomes 1.
  always_comb begin
    seed_d = seed_q;
    if (load) begin
      if (load_val == {SEED_W{1'b0}}) begin
        seed_d = {{(SEED_W-1){1'b0}}, 1'b1};
      end else begin
        seed_d = load_val;
      end
    end else if (step) begin
      seed_d = lfsr_step(seed_q);
    end else begin
      seed_d = seed_q;
    end
  end

  // Seed flop, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_q <= {SEED_W{1'b0}};
    end else begin
      seed_q <= seed_d;
    end
  end

  assign seed = seed_q;

endmodule

// File: rtl/generation_sequencer.sv
// Generation sequencer: launches the family generator, scores every family
// member through the fitness req/ack handshake, promotes the best member to
// parent and stops on a generation limit or fitness target.
// Optional feature macro: GEN_SEQ_TIMEOUT_EN (watchdog on generator/fitness waits).
module generation_sequencer
  import gen_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [GENOME_W-1:0]          init_parent,
  input  logic [SEED_W-1:0]            seed_init,
  input  logic [GEN_W-1:0]             max_gens,
  input  logic [FIT_W-1:0]             fit_target,
  output logic                         iter_start,
  output logic [SEED_W-1:0]            iter_seed,
  output logic [GENOME_W-1:0]          iter_parent,
  input  logic [GENOME_W*FAMILY_N-1:0] iter_family,
  input  logic                         iter_done,
  output logic                         fit_req,
  output logic [GENOME_W-1:0]          fit_genome,
  input  logic                         fit_ack,
  input  logic [FIT_W-1:0]             fit_score,
  output logic                         busy,
  output logic                         done,
  output logic [GENOME_W-1:0]          best_parent,
  output logic [FIT_W-1:0]             best_fit,
  output logic [GEN_W-1:0]             gen_count,
  output logic                         err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FAMILY_N - 1);

  gen_state_t                   state_q, state_d;
  logic [GENOME_W-1:0]          parent_q, parent_d;
  logic [GENOME_W*FAMILY_N-1:0] family_q, family_d;
  logic [IDX_W-1:0]             k_q, k_d, best_idx_q, best_idx_d;
  logic [FIT_W-1:0]             best_score_q, best_score_d;
  logic [FIT_W-1:0]             best_fit_q, best_fit_d, fit_target_q, fit_target_d;
  logic [GEN_W-1:0]             gen_count_q, gen_count_d, max_gens_q, max_gens_d;
  logic [GEN_W-1:0]             gen_next;
  logic                         fit_req_q, fit_req_d, iter_start_q, iter_start_d;
  logic                         busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                         seed_load, seed_step, wd_fire;

  gen_seq_lfsr u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_load),
    .load_val (seed_init),
    .step     (seed_step),
    .seed     (iter_seed)
  );

`ifdef GEN_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;

  // Count cycles spent waiting on the generator or on a single fitness request.
  always_comb begin
    wd_d    = {WD_W{1'b0}};
    wd_fire = 1'b0;
    if ((state_q == S_WAIT_IT && !iter_done) ||
        (state_q == S_EVAL && fit_req_q && !fit_ack)) begin
      if (wd_q == WD_W'(TIMEOUT - 1)) begin
        wd_fire = 1'b1;
        wd_d    = {WD_W{1'b0}};
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end else begin
      wd_d = {WD_W{1'b0}};
    end
  end

  // Watchdog counter flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= {WD_W{1'b0}};
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_timeout;
  assign wd_fire        = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // Saturating generation counter increment.
  always_comb begin
    if (gen_count_q == {GEN_W{1'b1}}) begin
      gen_next = gen_count_q;
    end else begin
      gen_next = gen_count_q + GEN_W'(1);
    end
  end

  // Main FSM: launch, wait for family, score members, promote best, decide stop.
  always_comb begin
    state_d      = state_q;
    parent_d     = parent_q;
    family_d     = family_q;
    k_d          = k_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    best_fit_d   = best_fit_q;
    fit_target_d = fit_target_q;
    gen_count_d  = gen_count_q;
    max_gens_d   = max_gens_q;
    fit_req_d    = fit_req_q;
    err_d        = err_q;
    seed_load    = 1'b0;
    seed_step    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          parent_d     = init_parent;
          fit_target_d = fit_target;
          gen_count_d  = {GEN_W{1'b0}};
          best_fit_d   = {FIT_W{1'b0}};
          err_d        = 1'b0;
          seed_load    = 1'b1;
          state_d      = S_LAUNCH;
          if (max_gens == {GEN_W{1'b0}}) begin
            max_gens_d = GEN_W'(1);
          end else begin
            max_gens_d = max_gens;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_IT;
      end
      S_WAIT_IT: begin
        if (iter_done) begin
          family_d = iter_family;
          k_d      = {IDX_W{1'b0}};
          state_d  = S_EVAL;
        end else begin
          state_d = S_WAIT_IT;
        end
      end
      S_EVAL: begin
        if (fit_req_q) begin
          if (fit_ack) begin
            fit_req_d = 1'b0;
            // Member 0 seeds the argmax; later members need a strictly higher score.
            if (k_q == {IDX_W{1'b0}} || fit_score > best_score_q) begin
              best_score_d = fit_score;
              best_idx_d   = k_q;
            end else begin
              best_score_d = best_score_q;
            end
            if (k_q == LAST_IDX) begin
              state_d = S_UPDATE;
            end else begin
              k_d = k_q + IDX_W'(1);
            end
          end else begin
            fit_req_d = 1'b1;
          end
        end else begin
          fit_req_d = 1'b1;
        end
      end
      S_UPDATE: begin
        parent_d    = family_q[int'(best_idx_q)*GENOME_W +: GENOME_W];
        best_fit_d  = best_score_q;
        gen_count_d = gen_next;
        seed_step   = 1'b1;
        if (gen_next == max_gens_q || best_score_q >= fit_target_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LAUNCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // An expired watchdog abandons the generation and keeps the last results.
    if (wd_fire) begin
      err_d     = 1'b1;
      fit_req_d = 1'b0;
      state_d   = S_DONE;
    end else begin
      err_d = err_d;
    end
  end

  // Status flags decoded from the next state so they leave the block registered.
  always_comb begin
    iter_start_d = (state_d == S_LAUNCH);
    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d       = (state_d == S_DONE);
  end

  // State and datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      parent_q     <= {GENOME_W{1'b0}};
      family_q     <= {(GENOME_W*FAMILY_N){1'b0}};
      k_q          <= {IDX_W{1'b0}};
      best_idx_q   <= {IDX_W{1'b0}};
      best_score_q <= {FIT_W{1'b0}};
      best_fit_q   <= {FIT_W{1'b0}};
      fit_target_q <= {FIT_W{1'b0}};
      gen_count_q  <= {GEN_W{1'b0}};
      max_gens_q   <= {GEN_W{1'b0}};
      fit_req_q    <= 1'b0;
      iter_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      parent_q     <= parent_d;
      family_q     <= family_d;
      k_q          <= k_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      best_fit_q   <= best_fit_d;
      fit_target_q <= fit_target_d;
      gen_count_q  <= gen_count_d;
      max_gens_q   <= max_gens_d;
      fit_req_q    <= fit_req_d;
      iter_start_q <= iter_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign iter_start  = iter_start_q;
  assign iter_parent = parent_q;
  assign best_parent = parent_q;
  assign fit_req     = fit_req_q;
  assign fit_genome  = family_q[int'(k_q)*GENOME_W +: GENOME_W];
  assign busy        = busy_q;
  assign done        = done_q;
  assign best_fit    = best_fit_q;
  assign gen_count   = gen_count_q;
  assign err         = err_q;

endmodule

// File: tb/tb_generation_sequencer.sv
// Scoreboard bench for generation_sequencer: stimulus pushes the expected final
// result of each run, a monitor pops and compares when done rises. A combined
// environment process models the family generator and the fitness unit.
module tb_generation_sequencer;
  import gen_pkg::*;

  typedef struct {
    logic [GENOME_W-1:0] parent;
    logic [FIT_W-1:0]    fit;
    logic [GEN_W-1:0]    gens;
    logic [SEED_W-1:0]   seed;
    int                  starts;
    logic                err;
    int                  base;
  } exp_t;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         start = 1'b0;
  logic [GENOME_W-1:0]          init_parent = '0;
  logic [SEED_W-1:0]            seed_init = '0;
  logic [GEN_W-1:0]             max_gens = '0;
  logic [FIT_W-1:0]             fit_target = '0;
  logic                         iter_start;
  logic [SEED_W-1:0]            iter_seed;
  logic [GENOME_W-1:0]          iter_parent;
  logic [GENOME_W*FAMILY_N-1:0] iter_family = '0;
  logic                         iter_done = 1'b0;
  logic                         fit_req;
  logic [GENOME_W-1:0]          fit_genome;
  logic                         fit_ack = 1'b0;
  logic [FIT_W-1:0]             fit_score = '0;
  logic                         busy, done;
  logic [GENOME_W-1:0]          best_parent;
  logic [FIT_W-1:0]             best_fit;
  logic [GEN_W-1:0]             gen_count;
  logic                         err;

  int tests = 0;
  int fails = 0;
  int starts_cnt = 0;
  int ack_idx = 0;
  int lat = 0;
  int t_iter = 3;
  bit gen_hold = 1'b0;
  logic [FIT_W-1:0]    score_tbl [FAMILY_N];
  logic [GENOME_W-1:0] fam_store [FAMILY_N];
  exp_t exp_q[$];

  generation_sequencer #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .init_parent(init_parent),
    .seed_init(seed_init), .max_gens(max_gens), .fit_target(fit_target),
    .iter_start(iter_start), .iter_seed(iter_seed), .iter_parent(iter_parent),
    .iter_family(iter_family), .iter_done(iter_done), .fit_req(fit_req),
    .fit_genome(fit_genome), .fit_ack(fit_ack), .fit_score(fit_score),
    .busy(busy), .done(done), .best_parent(best_parent), .best_fit(best_fit),
    .gen_count(gen_count), .err(err)
  );

  always #5 clk = ~clk;

  // Generator model: member 0 is the parent, member k flips a byte at bit k*20.
  function automatic logic [GENOME_W-1:0] mk_member(input logic [GENOME_W-1:0] p, input int k);
    logic [GENOME_W-1:0] m;
    m = p;
    if (k != 0) m[k*20 +: 8] = m[k*20 +: 8] ^ (8'hA5 + 8'(k));
    return m;
  endfunction

  task automatic chk(input string name, input logic [GENOME_W-1:0] act, input logic [GENOME_W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic chk_zero(input string tag);
    logic [GENOME_W-1:0] z;
    z = '0;
    chk({tag, "_iter_start"}, GENOME_W'(iter_start), z);
    chk({tag, "_fit_req"}, GENOME_W'(fit_req), z);
    chk({tag, "_busy"}, GENOME_W'(busy), z);
    chk({tag, "_done"}, GENOME_W'(done), z);
    chk({tag, "_err"}, GENOME_W'(err), z);
    chk({tag, "_iter_seed"}, GENOME_W'(iter_seed), z);
    chk({tag, "_iter_parent"}, iter_parent, z);
    chk({tag, "_best_parent"}, best_parent, z);
    chk({tag, "_best_fit"}, GENOME_W'(best_fit), z);
    chk({tag, "_gen_count"}, GENOME_W'(gen_count), z);
  endtask

  task automatic expect_result(input logic [GENOME_W-1:0] p, input logic [FIT_W-1:0] f,
                               input logic [GEN_W-1:0] g, input logic [SEED_W-1:0] s,
                               input int n, input logic e);
    exp_t x;
    x.parent = p; x.fit = f; x.gens = g; x.seed = s; x.starts = n; x.err = e;
    x.base = starts_cnt;
    exp_q.push_back(x);
  endtask

  task automatic issue(input logic [GENOME_W-1:0] p, input logic [SEED_W-1:0] s,
                       input logic [GEN_W-1:0] mg, input logic [FIT_W-1:0] tgt);
    @(negedge clk);
    init_parent = p; seed_init = s; max_gens = mg; fit_target = tgt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      tests++; fails++;
      $display("FAIL wait_done: no done within %0d cycles", budget);
    end
  endtask

  task automatic set_scores(input logic [FIT_W-1:0] a, b, c, d, e);
    score_tbl[0] = a; score_tbl[1] = b; score_tbl[2] = c; score_tbl[3] = d; score_tbl[4] = e;
  endtask

  // Environment: family generator and fitness unit, both acting on the falling edge.
  initial begin : env
    int gcnt;
    int wcnt;
    gcnt = -1;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        iter_done = 1'b0; fit_ack = 1'b0; gcnt = -1; wcnt = 0; ack_idx = 0;
      end else begin
        if (iter_start) begin
          gcnt = t_iter; ack_idx = 0; iter_done = 1'b0;
        end else if (iter_done) begin
          iter_done = 1'b0;
        end else if (gcnt > 0) begin
          gcnt--;
        end else if (gcnt == 0 && !gen_hold) begin
          for (int k = 0; k < FAMILY_N; k++) begin
            fam_store[k] = mk_member(iter_parent, k);
            iter_family[k*GENOME_W +: GENOME_W] = fam_store[k];
          end
          iter_done = 1'b1;
          gcnt = -1;
        end
        if (fit_ack) begin
          fit_ack = 1'b0;
          ack_idx++;
        end
        if (fit_req) begin
          if (wcnt >= lat) begin
            chk("fit_genome", fit_genome, fam_store[ack_idx % FAMILY_N]);
            fit_ack = 1'b1;
            fit_score = score_tbl[ack_idx % FAMILY_N];
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end else begin
          wcnt = 0;
        end
      end
    end
  end

  // Monitor: counts launches and checks the result whenever done rises.
  initial begin : monitor
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (iter_start === 1'b1) starts_cnt++;
      if (done === 1'b1 && done_prev !== 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done=1, expected no completion");
        end else begin
          e = exp_q.pop_front();
          chk("best_parent", best_parent, e.parent);
          chk("iter_parent", iter_parent, e.parent);
          chk("best_fit", GENOME_W'(best_fit), GENOME_W'(e.fit));
          chk("gen_count", GENOME_W'(gen_count), GENOME_W'(e.gens));
          chk("iter_seed", GENOME_W'(iter_seed), GENOME_W'(e.seed));
          chk("iter_starts", GENOME_W'(starts_cnt - e.base), GENOME_W'(e.starts));
          chk("err", GENOME_W'(err), GENOME_W'(e.err));
          chk("busy_at_done", GENOME_W'(busy), GENOME_W'(0));
        end
      end
      done_prev = done;
    end
  end

  initial begin : timeout_guard
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : stim
    logic [GENOME_W-1:0] p1, p2, p3, p4, p5, p6, p7;
    int n;
    p1 = 150'h1_2345_6789_ABCD_EF01_2345_6789_ABCD_EF01;
    p2 = 150'h3_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;
    p3 = 150'h2_DEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0;
    p4 = 150'h0_1111_2222_3333_4444_5555_6666_7777_8888;
    p5 = 150'h3_FFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
    p6 = 150'h1_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;
    p7 = 150'h2_0000_0000_0000_0000_0000_0000_0000_0001;

    // Reset state
    @(negedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: single generation, ties keep lower index -> member 1 with 20
    lat = 0;
    set_scores(16'd10, 16'd20, 16'd5, 16'd20, 16'd3);
    expect_result(mk_member(p1, 1), 16'd20, 16'd1, 32'h8020_0003, 1, 1'b0);
    issue(p1, 32'h1, 16'd1, 16'hFFFF);
    wait_done(500, n);

    // 2: target reached after generation 1 of 10; seed 2 steps to 1
    set_scores(16'd30, 16'd60, 16'd10, 16'd40, 16'd60);
    expect_result(mk_member(p2, 1), 16'd60, 16'd1, 32'h0000_0001, 1, 1'b0);
    issue(p2, 32'h2, 16'd10, 16'd50);
    wait_done(500, n);

    // 3: all zeros for 3 generations -> parent kept, 3 launches, 3 LFSR steps from 1
    set_scores(16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    expect_result(p3, 16'd0, 16'd3, 32'h6018_0001, 3, 1'b0);
    issue(p3, 32'h1, 16'd3, 16'hFFFF);
    wait_done(1500, n);

    // 4: zero seed loads 1, zero limit runs one generation; full tie keeps parent
    set_scores(16'd7, 16'd7, 16'd7, 16'd7, 16'd7);
    expect_result(p4, 16'd7, 16'd1, 32'h8020_0003, 1, 1'b0);
    issue(p4, 32'h0, 16'd0, 16'hFFFF);
    wait_done(500, n);

    // 5: two generations, last member wins each time, slower fitness unit
    lat = 2;
    set_scores(16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
    expect_result(mk_member(mk_member(p5, 4), 4), 16'd5, 16'd2, 32'h8020_0003, 2, 1'b0);
    issue(p5, 32'h2, 16'd2, 16'hFFFF);
    wait_done(1000, n);

    // 6: start while waiting for the generator is ignored
    lat = 1;
    set_scores(16'd10, 16'd20, 16'd5, 16'd20, 16'd3);
    expect_result(mk_member(p6, 1), 16'd20, 16'd1, 32'h8020_0003, 1, 1'b0);
    issue(p6, 32'h1, 16'd1, 16'hFFFF);
    issue(p7, 32'h77, 16'd5, 16'hFFFF);
    wait_done(500, n);

    // 7: reset in the middle of scoring member 2, then a clean restart
    n = 0;
    issue(p7, 32'h1, 16'd4, 16'hFFFF);
    while (!(ack_idx == 2 && fit_req === 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      tests++; fails++;
      $display("FAIL reach_eval_k2: member 2 request not seen within 500 cycles");
    end
    rst = 1'b1;
    #1 chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    expect_result(mk_member(p7, 1), 16'd20, 16'd1, 32'h8020_0003, 1, 1'b0);
    issue(p7, 32'h1, 16'd1, 16'hFFFF);
    wait_done(500, n);

`ifdef GEN_SEQ_TIMEOUT_EN
    // 8: generator never answers -> watchdog after 16 WAIT_IT cycles
    gen_hold = 1'b1;
    expect_result(p1, 16'd0, 16'd0, 32'h0000_0055, 1, 1'b1);
    issue(p1, 32'h55, 16'd3, 16'hFFFF);
    wait_done(200, n);
    chk("timeout_cycles", GENOME_W'(n), GENOME_W'(17));
    gen_hold = 1'b0;
`endif

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL pending_results: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
